// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle core: base opcodes,
// control FSM state encoding and datapath mux-select encodings.
package rv32i_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_WB       = 4'd4,
        ST_WB_NOP   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_WB_LD    = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_t;

    typedef enum logic [1:0] {
        ALU_B_RS2 = 2'd0,
        ALU_B_IMM = 2'd1
    } alu_b_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/rv32i_mem_timer.sv
// Memory-request wait timer.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one wait cycle
//   expired  : count has reached MEM_TIMEOUT-1
module rv32i_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TW          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    assign expired = (count == TW'(MEM_TIMEOUT - 1));

    // Saturates at the expiry value; the FSM leaves the wait state by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + TW'(1);
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
//   clk, rst   : clock, async active-high reset
//   opcode     : IR[6:0]
//   br_taken   : branch comparator result (used in BRANCH)
//   mem_ready  : memory ack, completes the current request this cycle
//   mem_req/mem_we/addr_sel : memory port control
//   ir_we, pc_we, pc_sel, rf_we : architectural register load controls
//   alu_a_sel, alu_b_sel, wb_sel : datapath mux selects
//   trap       : sticky fault flag (illegal opcode or memory timeout)
//   state_o    : current state encoding
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TW          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       rf_we,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [3:0] state_o
);

    ctrl_state_t state;
    logic        in_mem;
    logic        expired;
    alu_a_sel_t  a_sel;
    alu_b_sel_t  b_sel;
    wb_sel_t     w_sel;

    assign in_mem = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    // Held at zero outside memory states, so every request starts from zero.
    rv32i_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TW         (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_mem || mem_ready),
        .en     (in_mem && !mem_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state <= ST_FETCH;
                ST_FETCH:
                    if (mem_ready)    state <= ST_DECODE;
                    else if (expired) state <= ST_TRAP;
                ST_DECODE:
                    case (opcode)
                        OP, OP_IMM, LUI, AUIPC: state <= ST_EXEC;
                        LOAD, STORE:            state <= ST_MEM_ADDR;
                        BRANCH:                 state <= ST_BRANCH;
                        JAL, JALR:              state <= ST_JUMP;
                        MISC_MEM:               state <= ST_WB_NOP;
                        SYSTEM:                 state <= ST_TRAP;
                        default:                state <= ST_TRAP;
                    endcase
                ST_EXEC:     state <= ST_WB;
                ST_WB:       state <= ST_FETCH;
                ST_WB_NOP:   state <= ST_FETCH;
                ST_MEM_ADDR: state <= (opcode == LOAD) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:
                    if (mem_ready)    state <= ST_WB_LD;
                    else if (expired) state <= ST_TRAP;
                ST_WB_LD:    state <= ST_FETCH;
                ST_MEM_WR:
                    if (mem_ready)    state <= ST_FETCH;
                    else if (expired) state <= ST_TRAP;
                ST_BRANCH:   state <= ST_FETCH;
                ST_JUMP:     state <= ST_FETCH;
                ST_TRAP:     state <= ST_TRAP;
                default:     state <= ST_TRAP;
            endcase
        end
    end

    // Outputs decode from the state register; ir_we, pc_we in MEM_WR and
    // pc_sel in BRANCH follow their inputs combinationally.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        trap     = 1'b0;
        a_sel    = ALU_A_RS1;
        b_sel    = ALU_B_RS2;
        w_sel    = WB_ALU;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC, ST_WB: begin
                // The ALU is combinational, so its operands stay selected
                // while WB consumes the result.
                case (opcode)
                    OP_IMM:  b_sel = ALU_B_IMM;
                    LUI:     begin a_sel = ALU_A_ZERO; b_sel = ALU_B_IMM; end
                    AUIPC:   begin a_sel = ALU_A_PC;   b_sel = ALU_B_IMM; end
                    default: ;
                endcase
                if (state == ST_WB) begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            ST_WB_NOP: pc_we = 1'b1;
            ST_MEM_ADDR: b_sel = ALU_B_IMM;
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                b_sel    = ALU_B_IMM;
            end
            ST_WB_LD: begin
                rf_we = 1'b1;
                w_sel = WB_MEM;
                pc_we = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                b_sel    = ALU_B_IMM;
                pc_we    = mem_ready;
            end
            ST_BRANCH: begin
                a_sel  = ALU_A_PC;
                b_sel  = ALU_B_IMM;
                pc_we  = 1'b1;
                pc_sel = br_taken;
            end
            ST_JUMP: begin
                a_sel  = (opcode == JAL) ? ALU_A_PC : ALU_A_RS1;
                b_sel  = ALU_B_IMM;
                rf_we  = 1'b1;
                w_sel  = WB_PC4;
                pc_we  = 1'b1;
                pc_sel = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign alu_a_sel = a_sel;
    assign alu_b_sel = b_sel;
    assign wb_sel    = w_sel;
    assign state_o   = state;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
module tb_rv32i_mc_ctrl;
    import rv32i_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OP;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, trap;
    logic [1:0] alu_a_sel, alu_b_sel, wb_sel;
    logic [3:0] state_o;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .trap(trap), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Control bit masks inside the 7-bit ctl field of an expected vector.
    localparam logic [6:0] MREQ  = 7'h01;
    localparam logic [6:0] MWE   = 7'h02;
    localparam logic [6:0] ASEL  = 7'h04;
    localparam logic [6:0] IRWE  = 7'h08;
    localparam logic [6:0] PCWE  = 7'h10;
    localparam logic [6:0] PCSEL = 7'h20;
    localparam logic [6:0] RFWE  = 7'h40;

    logic [17:0] obs;
    assign obs = {state_o, trap, wb_sel, alu_b_sel, alu_a_sel,
                  rf_we, pc_sel, pc_we, ir_we, addr_sel, mem_we, mem_req};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [17:0] sb_q[$];

    function automatic logic [17:0] ev(input logic [3:0] st, input logic [6:0] ctl,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] wb, input logic tr);
        return {st, tr, wb, b, a, ctl};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [17:0] e);
        logic [17:0] want;
        sb_q.push_back(e);
        #1;
        want = sb_q.pop_front();
        check_eq(tag, {14'b0, obs}, {14'b0, want});
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic br, input logic [17:0] e);
        mem_ready = rdy;
        br_taken  = br;
        expect_now(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [6:0] opc, input int unsigned waits);
        opcode = opc;
        for (int unsigned i = 0; i < waits; i++)
            cyc(tag, 1'b0, 1'b0, ev(ST_FETCH, MREQ, 2'd0, 2'd0, 2'd0, 1'b0));
        cyc(tag, 1'b1, 1'b0, ev(ST_FETCH, MREQ | IRWE, 2'd0, 2'd0, 2'd0, 1'b0));
        cyc({tag, "_dec"}, 1'b1, 1'b0, ev(ST_DECODE, '0, 2'd0, 2'd0, 2'd0, 1'b0));
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] opc, input logic [1:0] a, input logic [1:0] b);
        fetch(tag, opc, 0);
        cyc({tag, "_exec"}, 1'b1, 1'b0, ev(ST_EXEC, '0, a, b, WB_ALU, 1'b0));
        cyc({tag, "_wb"}, 1'b1, 1'b0, ev(ST_WB, RFWE | PCWE, a, b, WB_ALU, 1'b0));
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        expect_now({tag, "_async"}, ev(ST_IDLE, '0, 2'd0, 2'd0, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc({tag, "_idle"}, 1'b0, 1'b0, ev(ST_IDLE, '0, 2'd0, 2'd0, 2'd0, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset: outputs zero for 3 cycles, IDLE once, then FETCH.
        mem_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            expect_now("rst_hold", ev(ST_IDLE, '0, 2'd0, 2'd0, 2'd0, 1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("idle", 1'b1, 1'b0, ev(ST_IDLE, '0, 2'd0, 2'd0, 2'd0, 1'b0));

        // ALU classes with zero-wait memory; mem_ready=1 outside requests is ignored.
        alu_instr("add",   OP,     ALU_A_RS1,  ALU_B_RS2);
        alu_instr("addi",  OP_IMM, ALU_A_RS1,  ALU_B_IMM);
        alu_instr("lui",   LUI,    ALU_A_ZERO, ALU_B_IMM);
        alu_instr("auipc", AUIPC,  ALU_A_PC,   ALU_B_IMM);

        // Load with 3 wait cycles in MEM_RD.
        fetch("lw", LOAD, 0);
        cyc("lw_addr", 1'b0, 1'b0, ev(ST_MEM_ADDR, '0, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        for (int unsigned i = 0; i < 3; i++)
            cyc("lw_wait", 1'b0, 1'b0, ev(ST_MEM_RD, MREQ | ASEL, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        cyc("lw_rd", 1'b1, 1'b0, ev(ST_MEM_RD, MREQ | ASEL, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        cyc("lw_wb", 1'b0, 1'b0, ev(ST_WB_LD, RFWE | PCWE, 2'd0, 2'd0, WB_MEM, 1'b0));

        // Branches taken then not taken.
        fetch("beq_t", BRANCH, 0);
        cyc("beq_t_br", 1'b0, 1'b1, ev(ST_BRANCH, PCWE | PCSEL, ALU_A_PC, ALU_B_IMM, 2'd0, 1'b0));
        fetch("beq_n", BRANCH, 0);
        cyc("beq_n_br", 1'b0, 1'b0, ev(ST_BRANCH, PCWE, ALU_A_PC, ALU_B_IMM, 2'd0, 1'b0));

        // Jumps and fence.
        fetch("jal", JAL, 0);
        cyc("jal_j", 1'b0, 1'b0, ev(ST_JUMP, RFWE | PCWE | PCSEL, ALU_A_PC, ALU_B_IMM, WB_PC4, 1'b0));
        fetch("jalr", JALR, 1);
        cyc("jalr_j", 1'b0, 1'b0, ev(ST_JUMP, RFWE | PCWE | PCSEL, ALU_A_RS1, ALU_B_IMM, WB_PC4, 1'b0));
        fetch("fence", MISC_MEM, 0);
        cyc("fence_nop", 1'b0, 1'b0, ev(ST_WB_NOP, PCWE, 2'd0, 2'd0, 2'd0, 1'b0));

        // Store with one wait cycle; pc_we only on the ready cycle.
        fetch("sw", STORE, 0);
        cyc("sw_addr", 1'b0, 1'b0, ev(ST_MEM_ADDR, '0, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        cyc("sw_wait", 1'b0, 1'b0, ev(ST_MEM_WR, MREQ | MWE | ASEL, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        cyc("sw_wr", 1'b1, 1'b0, ev(ST_MEM_WR, MREQ | MWE | ASEL | PCWE, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));

        // Ready on the last allowed cycle (16th) completes normally.
        fetch("fetch_edge", OP, 15);
        cyc("edge_exec", 1'b0, 1'b0, ev(ST_EXEC, '0, ALU_A_RS1, ALU_B_RS2, WB_ALU, 1'b0));
        cyc("edge_wb", 1'b0, 1'b0, ev(ST_WB, RFWE | PCWE, ALU_A_RS1, ALU_B_RS2, WB_ALU, 1'b0));

        // Fetch timeout: 16 request cycles, then sticky TRAP.
        for (int unsigned i = 0; i < 16; i++)
            cyc("to_wait", 1'b0, 1'b0, ev(ST_FETCH, MREQ, 2'd0, 2'd0, 2'd0, 1'b0));
        for (int unsigned i = 0; i < 3; i++)
            cyc("to_trap", 1'b1, 1'b0, ev(ST_TRAP, '0, 2'd0, 2'd0, 2'd0, 1'b1));
        reset_pulse("to_rst");
        cyc("to_refetch", 1'b0, 1'b0, ev(ST_FETCH, MREQ, 2'd0, 2'd0, 2'd0, 1'b0));

        // Illegal opcode (SYSTEM) traps after DECODE.
        fetch("sys", SYSTEM, 0);
        cyc("sys_trap", 1'b0, 1'b0, ev(ST_TRAP, '0, 2'd0, 2'd0, 2'd0, 1'b1));
        cyc("sys_stick", 1'b1, 1'b0, ev(ST_TRAP, '0, 2'd0, 2'd0, 2'd0, 1'b1));
        reset_pulse("sys_rst");

        // Reset in the middle of a store request.
        fetch("swr", STORE, 0);
        cyc("swr_addr", 1'b0, 1'b0, ev(ST_MEM_ADDR, '0, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        cyc("swr_wait", 1'b0, 1'b0, ev(ST_MEM_WR, MREQ | MWE | ASEL, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        expect_now("swr_pre", ev(ST_MEM_WR, MREQ | MWE | ASEL, ALU_A_RS1, ALU_B_IMM, 2'd0, 1'b0));
        reset_pulse("swr_rst");
        cyc("swr_restart", 1'b1, 1'b0, ev(ST_FETCH, MREQ | IRWE, 2'd0, 2'd0, 2'd0, 1'b0));

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
